mchan_burst_sequencer: RTL and testbench

- Accepts one 1D or 2D MCHAN transfer command (TX or RX) and sequences it into a stream of 1D bursts for the external-memory/TCDM datapath.
- A burst never exceeds MAX_BURST bytes and never crosses a MAX_BURST-aligned external address boundary.
- Sits between the MCHAN command queue and the TX/RX transfer units.
- Processes one command at a time and signals completion per transaction ID.

---
 rtl/mchan_pkg.sv | 39 +++
 rtl/mchan_burst_len_calc.sv | 29 ++
 rtl/mchan_burst_sequencer.sv | 177 +++++++++++++++++
 tb/tb_mchan_burst_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mchan_pkg.sv
// Shared MCHAN types and constants for the burst sequencer slice.
package mchan_pkg;

    localparam int MCHAN_MAX_BURST        = 256;
    localparam int MCHAN_ADDR_WIDTH       = 32;
    localparam int MCHAN_LEN_WIDTH        = 17;
    localparam int MCHAN_TWD_COUNT_WIDTH  = 32;
    localparam int MCHAN_TWD_STRIDE_WIDTH = 32;
    localparam int MCHAN_SID_WIDTH        = 2;

    localparam logic MCHAN_OP_TX = 1'b0;
    localparam logic MCHAN_OP_RX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } mchan_seq_state_e;

    typedef struct packed {
        logic                              opc;
        logic                              twd;
        logic [MCHAN_LEN_WIDTH-1:0]        len;
        logic [MCHAN_TWD_COUNT_WIDTH-1:0]  rows;
        logic [MCHAN_TWD_STRIDE_WIDTH-1:0] stride;
        logic [MCHAN_ADDR_WIDTH-1:0]       ext_add;
        logic [MCHAN_ADDR_WIDTH-1:0]       tcdm_add;
        logic [MCHAN_SID_WIDTH-1:0]        sid;
    } mchan_cmd_t;

    // A 1D command behaves as a single-row 2D command.
    function automatic logic [MCHAN_TWD_COUNT_WIDTH-1:0] mchan_eff_rows(
        input logic                             twd,
        input logic [MCHAN_TWD_COUNT_WIDTH-1:0] rows
    );
        return twd ? rows : MCHAN_TWD_COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/mchan_burst_len_calc.sv
// Burst length: the smaller of the bytes left in the row and the room
// before the next MAX_BURST-aligned external boundary.
module mchan_burst_len_calc #(
    parameter int LEN_WIDTH = 17,
    parameter int MAX_BURST = 256
) (
    input  logic [LEN_WIDTH-1:0]           row_rem_i,
    input  logic [$clog2(MAX_BURST)-1:0]   ext_off_i,
    output logic [$clog2(MAX_BURST):0]     burst_len_o,
    output logic                           row_end_o
);
    localparam int OFFS_W = $clog2(MAX_BURST);
    localparam int BLEN_W = OFFS_W + 1;
    localparam int CMP_W  = (LEN_WIDTH > BLEN_W) ? LEN_WIDTH : BLEN_W;

    logic [CMP_W-1:0] room;
    logic [CMP_W-1:0] rem_ext;
    logic [CMP_W-1:0] len_ext;

    always_comb begin
        room        = CMP_W'(MAX_BURST) - CMP_W'(ext_off_i);
        rem_ext     = CMP_W'(row_rem_i);
        len_ext     = (rem_ext < room) ? rem_ext : room;
        // len_ext never exceeds MAX_BURST, so it fits BLEN_W bits.
        burst_len_o = BLEN_W'(len_ext);
        row_end_o   = (len_ext == rem_ext);
    end

endmodule

// File: rtl/mchan_burst_sequencer.sv
// Splits one 1D/2D MCHAN command into boundary-respecting 1D bursts and
// pulses done_o with the command's transaction ID when finished.
module mchan_burst_sequencer
    import mchan_pkg::*;
#(
    parameter int ADDR_WIDTH       = MCHAN_ADDR_WIDTH,
    parameter int LEN_WIDTH        = MCHAN_LEN_WIDTH,
    parameter int TWD_COUNT_WIDTH  = MCHAN_TWD_COUNT_WIDTH,
    parameter int TWD_STRIDE_WIDTH = MCHAN_TWD_STRIDE_WIDTH,
    parameter int MAX_BURST        = MCHAN_MAX_BURST,
    parameter int SID_WIDTH        = MCHAN_SID_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          cmd_req_i,
    output logic                          cmd_gnt_o,
    input  logic                          cmd_opc_i,
    input  logic                          cmd_twd_i,
    input  logic [LEN_WIDTH-1:0]          cmd_len_i,
    input  logic [TWD_COUNT_WIDTH-1:0]    cmd_rows_i,
    input  logic [TWD_STRIDE_WIDTH-1:0]   cmd_stride_i,
    input  logic [ADDR_WIDTH-1:0]         cmd_ext_add_i,
    input  logic [ADDR_WIDTH-1:0]         cmd_tcdm_add_i,
    input  logic [SID_WIDTH-1:0]          cmd_sid_i,
    output logic                          burst_req_o,
    input  logic                          burst_gnt_i,
    output logic                          burst_opc_o,
    output logic [$clog2(MAX_BURST):0]    burst_len_o,
    output logic [ADDR_WIDTH-1:0]         burst_ext_add_o,
    output logic [ADDR_WIDTH-1:0]         burst_tcdm_add_o,
    output logic [SID_WIDTH-1:0]          burst_sid_o,
    output logic                          burst_last_o,
    output logic                          done_o,
    output logic [SID_WIDTH-1:0]          done_sid_o,
    output logic                          busy_o
);
    localparam int OFFS_W = $clog2(MAX_BURST);
    localparam int BLEN_W = OFFS_W + 1;

    mchan_seq_state_e              state_q, state_d;
    logic                          opc_q, opc_d;
    logic [SID_WIDTH-1:0]          sid_q, sid_d;
    logic [LEN_WIDTH-1:0]          len_q, len_d;
    logic [TWD_STRIDE_WIDTH-1:0]   stride_q, stride_d;
    logic [TWD_COUNT_WIDTH-1:0]    rows_q, rows_d;
    logic [LEN_WIDTH-1:0]          row_rem_q, row_rem_d;
    logic [ADDR_WIDTH-1:0]         row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0]         ext_q, ext_d;
    logic [ADDR_WIDTH-1:0]         tcdm_q, tcdm_d;

    mchan_cmd_t                    cmd_in;
    logic [BLEN_W-1:0]             blen;
    logic                          row_end;
    logic                          in_burst;
    logic [ADDR_WIDTH-1:0]         next_row_base;

    always_comb begin
        cmd_in          = '0;
        cmd_in.opc      = cmd_opc_i;
        cmd_in.twd      = cmd_twd_i;
        cmd_in.len      = cmd_len_i;
        cmd_in.rows     = cmd_rows_i;
        cmd_in.stride   = cmd_stride_i;
        cmd_in.ext_add  = cmd_ext_add_i;
        cmd_in.tcdm_add = cmd_tcdm_add_i;
        cmd_in.sid      = cmd_sid_i;
    end

    mchan_burst_len_calc #(
        .LEN_WIDTH (LEN_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) u_len_calc (
        .row_rem_i   (row_rem_q),
        .ext_off_i   (ext_q[OFFS_W-1:0]),
        .burst_len_o (blen),
        .row_end_o   (row_end)
    );

    assign next_row_base = row_base_q + ADDR_WIDTH'(stride_q);

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        sid_d      = sid_q;
        len_d      = len_q;
        stride_d   = stride_q;
        rows_d     = rows_q;
        row_rem_d  = row_rem_q;
        row_base_d = row_base_q;
        ext_d      = ext_q;
        tcdm_d     = tcdm_q;
        cmd_gnt_o  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_gnt_o = cmd_req_i;
                if (cmd_req_i) begin
                    opc_d      = cmd_in.opc;
                    sid_d      = cmd_in.sid;
                    len_d      = cmd_in.len;
                    stride_d   = cmd_in.stride;
                    rows_d     = mchan_eff_rows(cmd_in.twd, cmd_in.rows);
                    row_rem_d  = cmd_in.len;
                    row_base_d = cmd_in.ext_add;
                    ext_d      = cmd_in.ext_add;
                    tcdm_d     = cmd_in.tcdm_add;
                    state_d    = ((cmd_in.len == '0) || (rows_d == '0)) ? ST_DONE : ST_BURST;
                end
            end
            ST_BURST: begin
                if (burst_gnt_i) begin
                    ext_d     = ext_q + ADDR_WIDTH'(blen);
                    tcdm_d    = tcdm_q + ADDR_WIDTH'(blen);
                    row_rem_d = row_rem_q - LEN_WIDTH'(blen);
                    if (row_end) begin
                        if (rows_q == TWD_COUNT_WIDTH'(1)) begin
                            state_d = ST_DONE;
                        end else begin
                            // New row restarts at the strided external base;
                            // the TCDM side keeps packing contiguously.
                            rows_d     = rows_q - TWD_COUNT_WIDTH'(1);
                            row_base_d = next_row_base;
                            ext_d      = next_row_base;
                            row_rem_d  = len_q;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            opc_q      <= 1'b0;
            sid_q      <= '0;
            len_q      <= '0;
            stride_q   <= '0;
            rows_q     <= '0;
            row_rem_q  <= '0;
            row_base_q <= '0;
            ext_q      <= '0;
            tcdm_q     <= '0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            sid_q      <= sid_d;
            len_q      <= len_d;
            stride_q   <= stride_d;
            rows_q     <= rows_d;
            row_rem_q  <= row_rem_d;
            row_base_q <= row_base_d;
            ext_q      <= ext_d;
            tcdm_q     <= tcdm_d;
        end
    end

    // Burst fields are held at zero outside BURST so idle outputs stay quiet.
    assign in_burst         = (state_q == ST_BURST);
    assign burst_req_o      = in_burst;
    assign burst_opc_o      = in_burst & opc_q;
    assign burst_len_o      = in_burst ? blen : '0;
    assign burst_ext_add_o  = in_burst ? ext_q : '0;
    assign burst_tcdm_add_o = in_burst ? tcdm_q : '0;
    assign burst_sid_o      = in_burst ? sid_q : '0;
    assign burst_last_o     = in_burst && (rows_q == TWD_COUNT_WIDTH'(1)) && row_end;
    assign done_o           = (state_q == ST_DONE);
    assign done_sid_o       = done_o ? sid_q : '0;
    assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mchan_burst_sequencer.sv
// Directed bench for mchan_burst_sequencer: stimulus queues expected bursts
// and done IDs, a negedge monitor pops and compares them as the DUT emits.
module tb_mchan_burst_sequencer;
    import mchan_pkg::*;

    localparam int AW  = 32;
    localparam int LW  = 17;
    localparam int CW  = 32;
    localparam int SW  = 32;
    localparam int MB  = 256;
    localparam int IW  = 2;
    localparam int BLW = $clog2(MB) + 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cmd_req;
    logic           cmd_gnt;
    logic           cmd_opc;
    logic           cmd_twd;
    logic [LW-1:0]  cmd_len;
    logic [CW-1:0]  cmd_rows;
    logic [SW-1:0]  cmd_stride;
    logic [AW-1:0]  cmd_ext;
    logic [AW-1:0]  cmd_tcdm;
    logic [IW-1:0]  cmd_sid;
    logic           burst_req;
    logic           burst_gnt;
    logic           burst_opc;
    logic [BLW-1:0] burst_len;
    logic [AW-1:0]  burst_ext;
    logic [AW-1:0]  burst_tcdm;
    logic [IW-1:0]  burst_sid;
    logic           burst_last;
    logic           done;
    logic [IW-1:0]  done_sid;
    logic           busy;

    always #5 clk = ~clk;

    mchan_burst_sequencer #(
        .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TWD_COUNT_WIDTH(CW),
        .TWD_STRIDE_WIDTH(SW), .MAX_BURST(MB), .SID_WIDTH(IW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_req_i(cmd_req), .cmd_gnt_o(cmd_gnt), .cmd_opc_i(cmd_opc),
        .cmd_twd_i(cmd_twd), .cmd_len_i(cmd_len), .cmd_rows_i(cmd_rows),
        .cmd_stride_i(cmd_stride), .cmd_ext_add_i(cmd_ext),
        .cmd_tcdm_add_i(cmd_tcdm), .cmd_sid_i(cmd_sid),
        .burst_req_o(burst_req), .burst_gnt_i(burst_gnt), .burst_opc_o(burst_opc),
        .burst_len_o(burst_len), .burst_ext_add_o(burst_ext),
        .burst_tcdm_add_o(burst_tcdm), .burst_sid_o(burst_sid),
        .burst_last_o(burst_last), .done_o(done), .done_sid_o(done_sid),
        .busy_o(busy)
    );

    typedef struct packed {
        logic           opc;
        logic [BLW-1:0] len;
        logic [AW-1:0]  ext;
        logic [AW-1:0]  tcdm;
        logic [IW-1:0]  sid;
        logic           last;
    } exp_burst_t;

    exp_burst_t    exp_q[$];
    logic [IW-1:0] done_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    task automatic push_b(input logic opc, input logic [IW-1:0] sid, input int len,
                          input logic [AW-1:0] ext, input logic [AW-1:0] tcdm, input logic last);
        exp_burst_t e;
        logic [31:0] l;
        l      = len;
        e.opc  = opc;
        e.len  = l[BLW-1:0];
        e.ext  = ext;
        e.tcdm = tcdm;
        e.sid  = sid;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Monitor: compare each accepted burst and each done pulse against the queues.
    always @(negedge clk) begin
        exp_burst_t e;
        if (rst_n) begin
            if (burst_req && burst_gnt) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_burst: got len %0d ext 0x%0h, expected no burst", burst_len, burst_ext);
                end else begin
                    e = exp_q.pop_front();
                    check("burst_len", 64'(burst_len), 64'(e.len));
                    check("burst_ext", 64'(burst_ext), 64'(e.ext));
                    check("burst_tcdm", 64'(burst_tcdm), 64'(e.tcdm));
                    check("burst_opc", 64'(burst_opc), 64'(e.opc));
                    check("burst_sid", 64'(burst_sid), 64'(e.sid));
                    check("burst_last", 64'(burst_last), 64'(e.last));
                    if (e.last) exp_done_cyc = cyc + 1;
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done sid %0d, expected no done", done_sid);
                end else begin
                    check("done_sid", 64'(done_sid), 64'(done_q.pop_front()));
                    check("done_latency", 64'(cyc), 64'(exp_done_cyc));
                end
            end
        end
    end

    task automatic issue(input logic opc, input logic twd, input int len, input int rows,
                         input logic [SW-1:0] stride, input logic [AW-1:0] ext,
                         input logic [AW-1:0] tcdm, input logic [IW-1:0] sid, input logic zero);
        logic [31:0] l;
        logic [31:0] r;
        l = len;
        r = rows;
        @(posedge clk); #2;
        cmd_opc    = opc;
        cmd_twd    = twd;
        cmd_len    = l[LW-1:0];
        cmd_rows   = r;
        cmd_stride = stride;
        cmd_ext    = ext;
        cmd_tcdm   = tcdm;
        cmd_sid    = sid;
        cmd_req    = 1'b1;
        if (zero) exp_done_cyc = cyc + 1;
        #1;
        check("cmd_gnt_idle", 64'(cmd_gnt), 64'd1);
        @(posedge clk); #2;
        cmd_req = 1'b0;
        if (zero) begin
            check("zero_no_burst", 64'(burst_req), 64'd0);
            check("zero_done_next", 64'(done), 64'd1);
        end else begin
            check("first_burst_latency", 64'(burst_req), 64'd1);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 500) begin
            @(posedge clk); #2;
            k++;
        end
        check({name, "_finished"}, 64'(busy), 64'd0);
        check({name, "_bursts_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_done_drained"}, 64'(done_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        logic [BLW-1:0] h_len;
        logic [AW-1:0]  h_ext;
        logic [AW-1:0]  h_tcdm;
        logic           h_last;

        rst_n = 1'b0; cmd_req = 1'b0; cmd_opc = 1'b0; cmd_twd = 1'b0;
        cmd_len = '0; cmd_rows = '0; cmd_stride = '0; cmd_ext = '0;
        cmd_tcdm = '0; cmd_sid = '0; burst_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_burst_req", 64'(burst_req), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_burst_len", 64'(burst_len), 64'd0);
        check("rst_cmd_gnt", 64'(cmd_gnt), 64'd0);
        rst_n = 1'b1;

        // 1D TX, single burst.
        push_b(MCHAN_OP_TX, 2'd1, 64, 32'h1000, 32'h100, 1'b1);
        done_q.push_back(2'd1);
        issue(MCHAN_OP_TX, 1'b0, 64, 0, '0, 32'h1000, 32'h100, 2'd1, 1'b0);
        wait_idle("tx64");

        // 1D RX spanning several MAX_BURST boundaries.
        push_b(MCHAN_OP_RX, 2'd2, 16,  32'h10F0, 32'h100, 1'b0);
        push_b(MCHAN_OP_RX, 2'd2, 256, 32'h1100, 32'h110, 1'b0);
        push_b(MCHAN_OP_RX, 2'd2, 256, 32'h1200, 32'h210, 1'b0);
        push_b(MCHAN_OP_RX, 2'd2, 72,  32'h1300, 32'h310, 1'b1);
        done_q.push_back(2'd2);
        issue(MCHAN_OP_RX, 1'b0, 600, 0, '0, 32'h10F0, 32'h100, 2'd2, 1'b0);
        wait_idle("rx600");

        // 2D, three rows with external stride.
        push_b(MCHAN_OP_TX, 2'd3, 32, 32'h2000, 32'h00, 1'b0);
        push_b(MCHAN_OP_TX, 2'd3, 32, 32'h2400, 32'h20, 1'b0);
        push_b(MCHAN_OP_TX, 2'd3, 32, 32'h2800, 32'h40, 1'b1);
        done_q.push_back(2'd3);
        issue(MCHAN_OP_TX, 1'b1, 32, 3, 32'h400, 32'h2000, 32'h0, 2'd3, 1'b0);
        wait_idle("twd3");

        // Back-pressure mid-stream with a competing command request.
        push_b(MCHAN_OP_TX, 2'd0, 256, 32'h000, 32'h000, 1'b0);
        push_b(MCHAN_OP_TX, 2'd0, 256, 32'h100, 32'h100, 1'b0);
        push_b(MCHAN_OP_TX, 2'd0, 88,  32'h200, 32'h200, 1'b1);
        done_q.push_back(2'd0);
        issue(MCHAN_OP_TX, 1'b0, 600, 0, '0, 32'h0, 32'h0, 2'd0, 1'b0);
        @(posedge clk); #2;
        burst_gnt = 1'b0;
        cmd_req   = 1'b1;
        cmd_len   = 17'd5;
        #1;
        h_len = burst_len; h_ext = burst_ext; h_tcdm = burst_tcdm; h_last = burst_last;
        check("stall_second_burst_ext", 64'(h_ext), 64'h100);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            check("stall_req", 64'(burst_req), 64'd1);
            check("stall_len", 64'(burst_len), 64'(h_len));
            check("stall_ext", 64'(burst_ext), 64'(h_ext));
            check("stall_tcdm", 64'(burst_tcdm), 64'(h_tcdm));
            check("stall_last", 64'(burst_last), 64'(h_last));
            check("stall_cmd_gnt", 64'(cmd_gnt), 64'd0);
        end
        burst_gnt = 1'b1;
        cmd_req   = 1'b0;
        wait_idle("stall");

        // Zero-length and zero-row commands complete without bursts.
        done_q.push_back(2'd1);
        issue(MCHAN_OP_TX, 1'b0, 0, 0, '0, 32'h5000, 32'h0, 2'd1, 1'b1);
        wait_idle("len0");
        done_q.push_back(2'd2);
        issue(MCHAN_OP_RX, 1'b1, 16, 0, 32'h100, 32'h6000, 32'h0, 2'd2, 1'b1);
        wait_idle("rows0");

        // External address wraps through zero.
        push_b(MCHAN_OP_RX, 2'd3, 16, 32'hFFFF_FFF0, 32'h40, 1'b0);
        push_b(MCHAN_OP_RX, 2'd3, 16, 32'h0000_0000, 32'h50, 1'b1);
        done_q.push_back(2'd3);
        issue(MCHAN_OP_RX, 1'b0, 32, 0, '0, 32'hFFFF_FFF0, 32'h40, 2'd3, 1'b0);
        wait_idle("wrap");

        // Reset during the second burst aborts silently.
        push_b(MCHAN_OP_RX, 2'd2, 16,  32'h10F0, 32'h100, 1'b0);
        push_b(MCHAN_OP_RX, 2'd2, 256, 32'h1100, 32'h110, 1'b0);
        push_b(MCHAN_OP_RX, 2'd2, 256, 32'h1200, 32'h210, 1'b0);
        push_b(MCHAN_OP_RX, 2'd2, 72,  32'h1300, 32'h310, 1'b1);
        done_q.push_back(2'd2);
        issue(MCHAN_OP_RX, 1'b0, 600, 0, '0, 32'h10F0, 32'h100, 2'd2, 1'b0);
        @(posedge clk); #2;
        check("abort_second_burst_ext", 64'(burst_ext), 64'h1100);
        rst_n = 1'b0;
        @(posedge clk); #2;
        check("abort_burst_req", 64'(burst_req), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_ext", 64'(burst_ext), 64'd0);
        exp_q.delete();
        done_q.delete();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        push_b(MCHAN_OP_TX, 2'd0, 8, 32'h3003, 32'h7, 1'b1);
        done_q.push_back(2'd0);
        issue(MCHAN_OP_TX, 1'b0, 8, 0, '0, 32'h3003, 32'h7, 2'd0, 1'b0);
        wait_idle("after_reset");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
